// File: rtl/n64_joybus_pkg.sv
// Shared constants for the Joybus link controller: FSM encodings, line ownership
// values, command bytes and a saturating counter helper.
package n64_joybus_pkg;

    localparam logic [2:0] ST_ARM        = 3'd0;
    localparam logic [2:0] ST_IDLE_RX    = 3'd1;
    localparam logic [2:0] ST_TURNAROUND = 3'd2;
    localparam logic [2:0] ST_TX_ACTIVE  = 3'd3;
    localparam logic [2:0] ST_TX_RECOVER = 3'd4;

    localparam logic OP_RX = 1'b0;
    localparam logic OP_TX = 1'b1;

    localparam logic [7:0] INFO   = 8'h00;
    localparam logic [7:0] STATUS = 8'h01;
    localparam logic [7:0] READ   = 8'h02;
    localparam logic [7:0] WRITE  = 8'h03;
    localparam logic [7:0] RESET  = 8'hFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/n64_joybus_link_ctrl_if.sv
// Handshake/bus bundle between the Rx front end, the link controller and the Tx block.
interface n64_joybus_link_ctrl_if;
    logic        rx_done_tgl;
    logic [7:0]  rx_cmd;
    logic [7:0]  rx_crc;
    logic        tx_done_tgl;
    logic        line_idle;
    logic        cur_operation;
    logic [7:0]  cmd;
    logic [7:0]  crc;
    logic        busy;
    logic        timeout_err;
    logic        dropped_cmd;
    logic [15:0] cmd_count;

    modport master (
        output rx_done_tgl, rx_cmd, rx_crc, tx_done_tgl, line_idle,
        input  cur_operation, cmd, crc, busy, timeout_err, dropped_cmd, cmd_count
    );

    modport slave (
        input  rx_done_tgl, rx_cmd, rx_crc, tx_done_tgl, line_idle,
        output cur_operation, cmd, crc, busy, timeout_err, dropped_cmd, cmd_count
    );
endinterface

// File: rtl/n64_joybus_link_ctrl_edge.sv
// Toggle-to-pulse converter; arm suppresses the output while prev is first loaded.
module toggle_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic arm,
    input  logic tgl,
    output logic edge_pulse
);
    logic prev_q;
    logic prev_d;

    always_comb prev_d = tgl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= 1'b0;
        else        prev_q <= prev_d;
    end

    assign edge_pulse = (tgl ^ prev_q) & ~arm;
endmodule

// File: rtl/n64_joybus_link_ctrl.sv
// Half-duplex Joybus sequencer: latches Rx commands, waits for line turnaround,
// grants Tx and returns the line to Rx on completion or timeout.
module n64_joybus_link_ctrl
    import n64_joybus_pkg::*;
#(
    parameter int unsigned TURNAROUND_CYCLES = 8,
    parameter int unsigned RECOVER_CYCLES    = 16,
    parameter int unsigned TIMEOUT_CYCLES    = 4096,
    parameter int unsigned TMR_W             = 13
) (
    input  logic                   sample_clk,
    input  logic                   reset_n,
    n64_joybus_link_ctrl_if.slave  bus
);
    localparam logic [TMR_W-1:0] ONE      = TMR_W'(1);
    localparam logic [TMR_W-1:0] TURN_CNT = TMR_W'(TURNAROUND_CYCLES);
    localparam logic [TMR_W-1:0] RECOV    = TMR_W'(RECOVER_CYCLES);
    localparam logic [TMR_W-1:0] TMO      = TMR_W'(TIMEOUT_CYCLES);

    logic [2:0]       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [TMR_W-1:0] idle_q, idle_d;
    logic             cur_op_q, cur_op_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [7:0]       crc_q, crc_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;
    logic             dropped_q, dropped_d;
    logic [15:0]      count_q, count_d;

    logic             arm;
    logic             rx_edge;
    logic             tx_edge;
    logic [TMR_W-1:0] timer_inc;
    logic [TMR_W-1:0] idle_inc;

    assign arm = (state_q == ST_ARM);

    toggle_edge_detect u_rx_edge (
        .clk(sample_clk), .rst_n(reset_n), .arm(arm), .tgl(bus.rx_done_tgl), .edge_pulse(rx_edge)
    );
    toggle_edge_detect u_tx_edge (
        .clk(sample_clk), .rst_n(reset_n), .arm(arm), .tgl(bus.tx_done_tgl), .edge_pulse(tx_edge)
    );

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        idle_d    = idle_q;
        cur_op_d  = cur_op_q;
        cmd_d     = cmd_q;
        crc_d     = crc_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        dropped_d = 1'b0;
        count_d   = count_q;
        timer_inc = (timer_q == '1) ? timer_q : timer_q + ONE;
        idle_inc  = idle_q + ONE;

        case (state_q)
            ST_ARM: state_d = ST_IDLE_RX;
            ST_IDLE_RX: begin
                if (rx_edge) begin
                    cmd_d   = bus.rx_cmd;
                    crc_d   = bus.rx_crc;
                    busy_d  = 1'b1;
                    timer_d = '0;
                    idle_d  = '0;
                    state_d = ST_TURNAROUND;
                end
            end
            ST_TURNAROUND: begin
                timer_d = timer_inc;
                idle_d  = bus.line_idle ? idle_inc : '0;
                // Grant takes priority if the idle run completes on the timeout cycle.
                if (bus.line_idle && idle_inc == TURN_CNT) begin
                    cur_op_d = OP_TX;
                    timer_d  = '0;
                    state_d  = ST_TX_ACTIVE;
                end else if (timer_inc >= TMO) begin
                    timeout_d = 1'b1;
                    timer_d   = '0;
                    state_d   = ST_TX_RECOVER;
                end
            end
            ST_TX_ACTIVE: begin
                if (tx_edge) begin
                    cur_op_d = OP_RX;
                    count_d  = sat_inc16(count_q);
                    timer_d  = '0;
                    state_d  = ST_TX_RECOVER;
                end else begin
                    timer_d = timer_inc;
                    if (timer_inc >= TMO) begin
                        cur_op_d  = OP_RX;
                        timeout_d = 1'b1;
                        timer_d   = '0;
                        state_d   = ST_TX_RECOVER;
                    end
                end
            end
            ST_TX_RECOVER: begin
                timer_d = timer_inc;
                if (timer_inc >= RECOV) begin
                    busy_d  = 1'b0;
                    timer_d = '0;
                    state_d = ST_IDLE_RX;
                end
            end
            default: begin
                cur_op_d = OP_RX;
                state_d  = ST_ARM;
            end
        endcase

        if (rx_edge && (state_q == ST_TURNAROUND || state_q == ST_TX_ACTIVE ||
                        state_q == ST_TX_RECOVER)) begin
            dropped_d = 1'b1;
        end
    end

    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_ARM;
            timer_q   <= '0;
            idle_q    <= '0;
            cur_op_q  <= OP_RX;
            cmd_q     <= '0;
            crc_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            dropped_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            idle_q    <= idle_d;
            cur_op_q  <= cur_op_d;
            cmd_q     <= cmd_d;
            crc_q     <= crc_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            dropped_q <= dropped_d;
            count_q   <= count_d;
        end
    end

    assign bus.cur_operation = cur_op_q;
    assign bus.cmd           = cmd_q;
    assign bus.crc           = crc_q;
    assign bus.busy          = busy_q;
    assign bus.timeout_err   = timeout_q;
    assign bus.dropped_cmd   = dropped_q;
    assign bus.cmd_count     = count_q;
endmodule

// File: tb/tb_n64_joybus_link_ctrl.sv
// Self-checking bench for n64_joybus_link_ctrl: directed scenarios plus randomized
// transactions judged against cycle-count expectations derived from the link rules.
module tb_n64_joybus_link_ctrl;
    import n64_joybus_pkg::*;

    localparam int TURN  = 8;
    localparam int RECOV = 16;
    localparam int TMO   = 4096;
    localparam int LIMIT = 5000;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    n64_joybus_link_ctrl_if bus ();

    n64_joybus_link_ctrl #(
        .TURNAROUND_CYCLES(TURN),
        .RECOVER_CYCLES(RECOV),
        .TIMEOUT_CYCLES(TMO),
        .TMR_W(13)
    ) dut (
        .sample_clk(clk),
        .reset_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_count;
    logic [7:0]  exp_cmd;
    logic [7:0]  exp_crc;
    bit          pat[$];
    logic [7:0]  pool[0:5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycles from latch to grant: first point where TURN consecutive idle samples are seen.
    function automatic int grant_index(input bit p[$]);
        int run = 0;
        for (int i = 0; i < p.size(); i++) begin
            run = p[i] ? run + 1 : 0;
            if (run == TURN) return i + 1;
        end
        return -1;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_curop"},   bus.cur_operation, OP_RX);
        chk({tag, "_busy"},    bus.busy, 0);
        chk({tag, "_cmd"},     bus.cmd, exp_cmd);
        chk({tag, "_crc"},     bus.crc, exp_crc);
        chk({tag, "_count"},   bus.cmd_count, exp_count);
        chk({tag, "_tmo"},     bus.timeout_err, 0);
        chk({tag, "_dropped"}, bus.dropped_cmd, 0);
    endtask

    task automatic start_cmd(input logic [7:0] c, input logic [7:0] r);
        bus.rx_cmd      = c;
        bus.rx_crc      = r;
        bus.rx_done_tgl = ~bus.rx_done_tgl;
        step();
        exp_cmd = c;
        exp_crc = r;
        chk("latch_busy", bus.busy, 1);
        chk("latch_cmd", bus.cmd, c);
        chk("latch_crc", bus.crc, r);
        chk("latch_curop", bus.cur_operation, OP_RX);
    endtask

    task automatic turnaround(input int exp_cycles);
        int n = 0;
        while (n < LIMIT && bus.cur_operation !== OP_TX) begin
            bus.line_idle = (n < pat.size()) ? pat[n] : 1'b1;
            step();
            n++;
        end
        chk("grant_cycles", n, exp_cycles);
    endtask

    task automatic finish_tx(input int delay);
        repeat (delay) step();
        chk("tx_hold_curop", bus.cur_operation, OP_TX);
        bus.tx_done_tgl = ~bus.tx_done_tgl;
        step();
        exp_count = (exp_count == 16'hFFFF) ? exp_count : exp_count + 16'd1;
        chk("done_curop", bus.cur_operation, OP_RX);
        chk("done_count", bus.cmd_count, exp_count);
        chk("done_tmo", bus.timeout_err, 0);
    endtask

    task automatic recover(input int exp_cycles);
        int n = 0;
        while (n < LIMIT && bus.busy !== 1'b0) begin
            step();
            n++;
        end
        chk("recover_cycles", n, exp_cycles);
    endtask

    task automatic all_idle_pat();
        pat.delete();
        repeat (TURN) pat.push_back(1'b1);
    endtask

    initial begin
        int  n;
        bit  seen_tx;
        pool[0] = INFO;  pool[1] = STATUS; pool[2] = READ;
        pool[3] = WRITE; pool[4] = RESET;  pool[5] = 8'h7E;
        exp_count = '0; exp_cmd = '0; exp_crc = '0;

        // Reset with both toggles held high; ARM must swallow the apparent edges.
        bus.rx_done_tgl = 1'b1;
        bus.tx_done_tgl = 1'b1;
        bus.line_idle   = 1'b1;
        bus.rx_cmd      = 8'h00;
        bus.rx_crc      = 8'h00;
        #2 rst_n = 1'b0;
        #20;
        check_idle("in_reset");
        @(negedge clk) rst_n = 1'b1;
        step();
        step();
        check_idle("post_arm");

        // Basic STATUS transaction.
        all_idle_pat();
        start_cmd(STATUS, 8'h5A);
        turnaround(grant_index(pat));
        finish_tx(3);
        recover(RECOV);
        check_idle("basic_end");

        // Idle run broken after 5 samples, plus a dropped command during TX_ACTIVE.
        pat = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1};
        start_cmd(READ, 8'h33);
        turnaround(grant_index(pat));
        chk("dropout_model", grant_index(pat), 14);
        bus.rx_cmd      = 8'hA5;
        bus.rx_crc      = 8'hC3;
        bus.rx_done_tgl = ~bus.rx_done_tgl;
        step();
        chk("dropped_pulse", bus.dropped_cmd, 1);
        chk("dropped_cmd_kept", bus.cmd, exp_cmd);
        step();
        chk("dropped_clear", bus.dropped_cmd, 0);
        finish_tx(2);
        recover(RECOV);
        check_idle("dropout_end");

        // Stale tx_done toggle while idle is ignored.
        bus.tx_done_tgl = ~bus.tx_done_tgl;
        step();
        step();
        check_idle("stale_tx");

        // No tx_done: TX_ACTIVE aborts after TMO cycles.
        all_idle_pat();
        start_cmd(WRITE, 8'h81);
        turnaround(TURN);
        n = 0;
        while (n < LIMIT && bus.cur_operation !== OP_RX) begin
            step();
            n++;
        end
        chk("tx_timeout_cycles", n, TMO);
        chk("tx_timeout_pulse", bus.timeout_err, 1);
        chk("tx_timeout_count", bus.cmd_count, exp_count);
        step();
        chk("tx_timeout_clear", bus.timeout_err, 0);
        recover(RECOV - 1);
        check_idle("tx_timeout_end");

        // Done edge on the timeout cycle: completion wins.
        all_idle_pat();
        start_cmd(INFO, 8'h10);
        turnaround(TURN);
        repeat (TMO - 1) step();
        chk("tie_no_early_abort", bus.cur_operation, OP_TX);
        finish_tx(0);
        recover(RECOV);
        check_idle("tie_end");

        // Line never idle: TURNAROUND aborts without granting, stale tx_done ignored.
        bus.line_idle = 1'b0;
        start_cmd(RESET, 8'hEE);
        bus.tx_done_tgl = ~bus.tx_done_tgl;
        n = 0;
        seen_tx = 1'b0;
        while (n < LIMIT && bus.timeout_err !== 1'b1) begin
            step();
            n++;
            if (bus.cur_operation === OP_TX) seen_tx = 1'b1;
        end
        chk("ta_timeout_cycles", n, TMO);
        chk("ta_never_granted", seen_tx, 0);
        chk("ta_count", bus.cmd_count, exp_count);
        step();
        recover(RECOV - 1);
        bus.line_idle = 1'b1;
        check_idle("ta_timeout_end");

        // Randomized transactions.
        for (int t = 0; t < 6; t++) begin
            logic [7:0] c;
            logic [7:0] r;
            int         len;
            c = pool[$urandom_range(0, 5)];
            r = 8'($urandom);
            pat.delete();
            len = $urandom_range(0, 12);
            for (int i = 0; i < len; i++) pat.push_back(bit'($urandom_range(0, 1)));
            repeat (TURN) pat.push_back(1'b1);
            start_cmd(c, r);
            turnaround(grant_index(pat));
            finish_tx($urandom_range(0, 10));
            recover(RECOV);
            check_idle("rand_end");
        end

        // Asynchronous reset in the middle of TX_ACTIVE.
        all_idle_pat();
        start_cmd(pool[$urandom_range(0, 5)], 8'h42);
        turnaround(TURN);
        step();
        rst_n = 1'b0;
        #1;
        exp_count = '0; exp_cmd = '0; exp_crc = '0;
        chk("async_rst_curop", bus.cur_operation, OP_RX);
        chk("async_rst_count", bus.cmd_count, 0);
        chk("async_rst_busy", bus.busy, 0);
        @(negedge clk) rst_n = 1'b1;
        step();
        step();
        check_idle("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
